// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller owning the program counter.
// Sequences the instruction-memory req/ack handshake, holds on decode
// stalls and applies NextPC redirects. All PCs are 30-bit word addresses.
//
// Optional feature macro: PC_DELAY_SLOT_EN
//   undefined: a redirect squashes the in-flight fetch (o_flush) and costs
//              one bubble cycle in REDIRECT.
//   defined:   MIPS branch delay slot; the outstanding fetch issues
//              normally and the PC jumps to the latched target on that
//              issue edge, with no bubble and no flush.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | one cycle after reset release, no request
// FETCH    | o_imem_req high, waiting for ack at pc
// HOLD     | word fetched but decode stalled, request dropped
// REDIRECT | one bubble cycle after a redirect, pc already at target
module pc_sequencer #(
  parameter logic [29:0] RESET_PC = 30'h0000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_imem_ack,
  input  logic        i_PCSrc,
  input  logic [29:0] i_target,
  output logic        o_imem_req,
  output logic [29:0] o_imem_addr,
  output logic [29:0] o_PC,
  output logic [29:0] o_PC_plus1,
  output logic        o_valid,
  output logic        o_flush
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_HOLD     = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] pc_plus1;
  logic        issue;

`ifdef PC_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [29:0] pend_tgt_q, pend_tgt_d;
`endif

  // Incremented PC and "a fetched word can be handed to decode now"
  always_comb begin
    pc_plus1 = pc_q + 30'd1;
    issue    = ((state_q == S_FETCH) && i_imem_ack && !i_stall) ||
               ((state_q == S_HOLD) && !i_stall);
  end

  // State, PC and pending-redirect registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
`ifdef PC_DELAY_SLOT_EN
      pend_q     <= 1'b0;
      pend_tgt_q <= 30'd0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
`ifdef PC_DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

  // Next state and next PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
`ifdef PC_DELAY_SLOT_EN
      S_FETCH, S_HOLD: begin
        if (issue) begin
          // delay slot issues now; jump takes effect on this edge
          state_d = S_FETCH;
          pend_d  = 1'b0;
          if (i_PCSrc)     pc_d = i_target;
          else if (pend_q) pc_d = pend_tgt_q;
          else             pc_d = pc_plus1;
        end else begin
          if (i_PCSrc) begin
            pend_d     = 1'b1;
            pend_tgt_d = i_target;
          end
          if ((state_q == S_FETCH) && i_imem_ack) state_d = S_HOLD;
        end
      end
      S_REDIRECT: begin
        if (i_PCSrc) pc_d    = i_target;
        else         state_d = S_FETCH;
      end
`else
      default: begin
        // redirect wins over ack and stall; a concurrent ack is dropped
        if (i_PCSrc) begin
          pc_d    = i_target;
          state_d = S_REDIRECT;
        end else if (issue) begin
          pc_d    = pc_plus1;
          state_d = S_FETCH;
        end else if (state_q == S_REDIRECT) begin
          state_d = S_FETCH;
        end else if ((state_q == S_FETCH) && i_imem_ack) begin
          state_d = S_HOLD;
        end
      end
`endif
    endcase
  end

  // Outputs decoded from state and current inputs
  always_comb begin
    o_imem_req  = (state_q == S_FETCH);
    o_imem_addr = pc_q;
    o_PC        = pc_q;
    o_PC_plus1  = pc_plus1;
`ifdef PC_DELAY_SLOT_EN
    o_valid     = issue;
    o_flush     = (state_q == S_REDIRECT) && i_PCSrc;
`else
    o_valid     = issue && !i_PCSrc;
    o_flush     = i_PCSrc && (state_q != S_IDLE);
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random
// stimulus, checked cycle by cycle against a behavioural fetch model
// through a scoreboard queue.
module tb_pc_sequencer;

  localparam logic [29:0] RESET_PC = 30'h100;

  logic        i_clk;
  logic        i_rst;
  logic        i_stall;
  logic        i_imem_ack;
  logic        i_PCSrc;
  logic [29:0] i_target;
  logic        o_imem_req;
  logic [29:0] o_imem_addr;
  logic [29:0] o_PC;
  logic [29:0] o_PC_plus1;
  logic        o_valid;
  logic        o_flush;

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stall     (i_stall),
    .i_imem_ack  (i_imem_ack),
    .i_PCSrc     (i_PCSrc),
    .i_target    (i_target),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .o_PC        (o_PC),
    .o_PC_plus1  (o_PC_plus1),
    .o_valid     (o_valid),
    .o_flush     (o_flush)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        req;
    logic [29:0] addr;
    logic [29:0] pc;
    logic [29:0] pcp1;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: phase of the fetch engine plus architectural PC
  localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_BUBBLE = 3;
  int          m_phase;
  logic [29:0] m_pc;
  logic        m_pend;
  logic [29:0] m_ptgt;

  task automatic model_step(input logic rst, input logic stall, input logic ack,
                            input logic pcsrc, input logic [29:0] tgt);
    exp_t e;
    logic can_issue;
    e.req = 1'b0; e.valid = 1'b0; e.flush = 1'b0;
    if (rst) begin
      m_phase = M_IDLE;
      m_pc    = RESET_PC;
      m_pend  = 1'b0;
    end
    e.addr = m_pc;
    e.pc   = m_pc;
    e.pcp1 = m_pc + 30'd1;
    if (!rst) begin
      if (m_phase == M_IDLE) begin
        m_phase = M_FETCH;
      end else begin
        e.req = (m_phase == M_FETCH);
        can_issue = (m_phase == M_FETCH) ? (ack && !stall) :
                    (m_phase == M_HOLD)  ? !stall : 1'b0;
`ifdef PC_DELAY_SLOT_EN
        if (m_phase == M_BUBBLE) begin
          e.flush = pcsrc;
          if (pcsrc) m_pc = tgt;
          else       m_phase = M_FETCH;
        end else if (can_issue) begin
          e.valid = 1'b1;
          m_pc    = pcsrc ? tgt : (m_pend ? m_ptgt : m_pc + 30'd1);
          m_pend  = 1'b0;
          m_phase = M_FETCH;
        end else begin
          if (pcsrc) begin m_pend = 1'b1; m_ptgt = tgt; end
          if (m_phase == M_FETCH && ack) m_phase = M_HOLD;
        end
`else
        if (pcsrc) begin
          e.flush = 1'b1;
          m_pc    = tgt;
          m_phase = M_BUBBLE;
        end else if (can_issue) begin
          e.valid = 1'b1;
          m_pc    = m_pc + 30'd1;
          m_phase = M_FETCH;
        end else if (m_phase == M_BUBBLE) begin
          m_phase = M_FETCH;
        end else if (m_phase == M_FETCH && ack) begin
          m_phase = M_HOLD;
        end
`endif
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic stall, input logic ack,
                     input logic pcsrc, input logic [29:0] tgt);
    @(negedge i_clk);
    i_rst      = rst;
    i_stall    = stall;
    i_imem_ack = ack;
    i_PCSrc    = pcsrc;
    i_target   = tgt;
    model_step(rst, stall, ack, pcsrc, tgt);
  endtask

  // Monitor: pop one expected record per cycle, sample just before posedge
  initial begin
    forever begin
      @(negedge i_clk);
      #4;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        tests++;
        if ({o_imem_req, o_imem_addr, o_PC, o_PC_plus1, o_valid, o_flush} !== mon_e) begin
          fails++;
          $display("FAIL cycle_check t=%0t got req=%b addr=%h pc=%h pcp1=%h valid=%b flush=%b exp req=%b addr=%h pc=%h pcp1=%h valid=%b flush=%b",
                   $time, o_imem_req, o_imem_addr, o_PC, o_PC_plus1, o_valid, o_flush,
                   mon_e.req, mon_e.addr, mon_e.pc, mon_e.pcp1, mon_e.valid, mon_e.flush);
        end
      end
    end
  end

  initial begin
    logic        r, s, a, p;
    logic [29:0] t;
    i_rst = 1'b1; i_stall = 1'b0; i_imem_ack = 1'b0; i_PCSrc = 1'b0; i_target = 30'd0;
    m_phase = M_IDLE; m_pc = RESET_PC; m_pend = 1'b0; m_ptgt = 30'd0;

    // reset, then streaming with single-cycle ack
    repeat (3) cyc(1, 0, 1, 0, 30'd0);
    repeat (5) cyc(0, 0, 1, 0, 30'd0);
    // redirect to 0x200, bubble, ack delayed 3 cycles
    cyc(0, 0, 0, 1, 30'h200);
    cyc(0, 0, 0, 0, 30'd0);
    repeat (3) cyc(0, 0, 0, 0, 30'd0);
    repeat (2) cyc(0, 0, 1, 0, 30'd0);
    // redirect to 0x300, ack with stall, stall held 2 cycles
    cyc(0, 0, 0, 1, 30'h300);
    cyc(0, 0, 0, 0, 30'd0);
    cyc(0, 1, 1, 0, 30'd0);
    repeat (2) cyc(0, 1, 1, 0, 30'd0);
    repeat (3) cyc(0, 0, 1, 0, 30'd0);
    // redirect to 0x10, then redirect to 0x40 with ack in the same cycle
    cyc(0, 0, 0, 1, 30'h10);
    cyc(0, 0, 0, 0, 30'd0);
    cyc(0, 0, 1, 1, 30'h40);
    repeat (4) cyc(0, 0, 1, 0, 30'd0);
    // wrap at the top of the address space
    cyc(0, 0, 0, 1, 30'h3FFFFFFF);
    cyc(0, 0, 0, 0, 30'd0);
    repeat (3) cyc(0, 0, 1, 0, 30'd0);
    // retarget during the bubble
    cyc(0, 0, 1, 1, 30'h80);
    cyc(0, 0, 1, 1, 30'h90);
    repeat (3) cyc(0, 0, 1, 0, 30'd0);
    // reset in the middle of HOLD
    cyc(0, 0, 0, 1, 30'h50);
    cyc(0, 0, 0, 0, 30'd0);
    cyc(0, 1, 1, 0, 30'd0);
    cyc(0, 1, 0, 0, 30'd0);
    cyc(1, 1, 1, 0, 30'd0);
    repeat (4) cyc(0, 0, 1, 0, 30'd0);
    // reset during the redirect bubble
    cyc(0, 0, 1, 1, 30'h60);
    cyc(1, 0, 1, 0, 30'd0);
    repeat (4) cyc(0, 0, 1, 0, 30'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) != 0);
      p = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) t = 30'h3FFFFFF0 | 30'($urandom_range(0, 15));
      else                          t = 30'($urandom);
      cyc(r, s, a, p, t);
    end
    cyc(0, 0, 0, 0, 30'd0);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge i_clk);
    #5;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
